// File: rtl/dmem_port_arbiter_if.sv
// ============================================================================
// dmem_port_arbiter_if : CPU, DMA and dmem signal bundle around the arbiter
// Revision: 1.0
// ============================================================================
`default_nettype none

interface dmem_port_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          cpu_req;
  logic          cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic [DW-1:0] cpu_rdata;
  logic          cpu_stall;

  logic          dma_req;
  logic          dma_we;
  logic [AW-1:0] dma_addr;
  logic [DW-1:0] dma_wdata;
  logic          dma_gnt;
  logic [DW-1:0] dma_rdata;
  logic          dma_rvalid;

  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  // Arbiter side
  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  dma_req, dma_we, dma_addr, dma_wdata,
    input  mem_rdata,
    output cpu_rdata, cpu_stall,
    output dma_gnt, dma_rdata, dma_rvalid,
    output mem_we, mem_addr, mem_wdata
  );

  // Requesters and memory side
  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output dma_req, dma_we, dma_addr, dma_wdata,
    output mem_rdata,
    input  cpu_rdata, cpu_stall,
    input  dma_gnt, dma_rdata, dma_rvalid,
    input  mem_we, mem_addr, mem_wdata
  );
endinterface

`default_nettype wire

// File: rtl/dmem_port_arbiter.sv
// ============================================================================
// dmem_port_arbiter : CPU-priority dmem port sharing with DMA starvation guard
// Revision: 1.0
// ============================================================================
`default_nettype none

module dmem_port_arbiter #(
  parameter int AW           = 32,
  parameter int DW           = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  wire                  clk,
  input  wire                  reset,
  dmem_port_arbiter_if.slave   bus
);

  localparam int CW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] C_LAST = CW'(STARVE_LIMIT - 1);

  typedef enum logic [0:0] {
    PRI_CPU   = 1'b0,
    FORCE_DMA = 1'b1
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic          dma_rvalid_q;
  logic [DW-1:0] dma_rdata_q;
  logic          gnt;

  // Reset gates the grant so nothing reaches dmem while reset is high
  assign gnt = ~reset & bus.dma_req & ((state == FORCE_DMA) | ~bus.cpu_req);

  always_comb begin
    bus.dma_gnt    = gnt;
    bus.cpu_stall  = bus.cpu_req & gnt;
    bus.mem_addr   = gnt ? bus.dma_addr  : bus.cpu_addr;
    bus.mem_wdata  = gnt ? bus.dma_wdata : bus.cpu_wdata;
    bus.mem_we     = ~reset & (gnt ? bus.dma_we : (bus.cpu_req & bus.cpu_we));
    bus.cpu_rdata  = bus.mem_rdata;
    bus.dma_rdata  = dma_rdata_q;
    bus.dma_rvalid = dma_rvalid_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= PRI_CPU;
      cnt          <= '0;
      dma_rvalid_q <= 1'b0;
      dma_rdata_q  <= '0;
    end else begin
      dma_rvalid_q <= gnt & ~bus.dma_we;
      if (gnt & ~bus.dma_we) begin
        dma_rdata_q <= bus.mem_rdata;
      end
      case (state)
        PRI_CPU: begin
          if (bus.dma_req & bus.cpu_req) begin
            if (cnt == C_LAST) begin
              state <= FORCE_DMA;
              cnt   <= '0;
            end else begin
              cnt <= cnt + CW'(1);
            end
          end else begin
            cnt <= '0;
          end
        end
        FORCE_DMA: begin
          state <= PRI_CPU;
          cnt   <= '0;
        end
        default: begin
          state <= PRI_CPU;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_dmem_port_arbiter.sv
// ============================================================================
// tb_dmem_port_arbiter : randomized and directed checks against a reference model
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_dmem_port_arbiter;

  localparam int AW    = 32;
  localparam int DW    = 32;
  localparam int LIMIT = 4;

  logic clk;
  logic rst;

  dmem_port_arbiter_if #(.AW(AW), .DW(DW)) bus ();

  dmem_port_arbiter #(.AW(AW), .DW(DW), .STARVE_LIMIT(LIMIT)) dut (
    .clk   (clk),
    .reset (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [DW-1:0] ram [0:63];
  assign bus.mem_rdata = ram[bus.mem_addr[7:2]];
  always @(posedge clk) begin
    if (bus.mem_we) ram[bus.mem_addr[7:2]] <= bus.mem_wdata;
  end

  // Reference model state
  logic [DW-1:0] ref_mem [0:63];
  int            denials;
  logic          exp_rvalid;
  logic [DW-1:0] exp_rdata;
  logic          last_gnt, last_stall;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    denials    = 0;
    exp_rvalid = 1'b0;
    exp_rdata  = '0;
  endtask

  // Called just after a falling edge; returns just after the next falling edge
  task automatic step(input logic cr, input logic cw, input logic [AW-1:0] ca,
                      input logic [DW-1:0] cd, input logic dr, input logic dw,
                      input logic [AW-1:0] da, input logic [DW-1:0] dd);
    logic          forced, e_gnt, e_stall, e_we;
    logic [AW-1:0] e_addr;
    bus.cpu_req = cr; bus.cpu_we = cw; bus.cpu_addr = ca; bus.cpu_wdata = cd;
    bus.dma_req = dr; bus.dma_we = dw; bus.dma_addr = da; bus.dma_wdata = dd;
    #1;
    forced  = (denials == LIMIT);
    e_gnt   = dr && (forced || !cr);
    e_stall = cr && e_gnt;
    e_we    = e_gnt ? dw : (cr && cw);
    e_addr  = e_gnt ? da : ca;
    check_val("dma_gnt",    bus.dma_gnt,    e_gnt);
    check_val("cpu_stall",  bus.cpu_stall,  e_stall);
    check_val("mem_we",     bus.mem_we,     e_we);
    check_val("dma_rvalid", bus.dma_rvalid, exp_rvalid);
    check_val("dma_rdata",  bus.dma_rdata,  exp_rdata);
    if (e_gnt || cr) check_val("mem_addr", bus.mem_addr, e_addr);
    if (e_we) check_val("mem_wdata", bus.mem_wdata, e_gnt ? dd : cd);
    if (cr && !cw && !e_stall) check_val("cpu_rdata", bus.cpu_rdata, ref_mem[ca[7:2]]);
    last_gnt   = bus.dma_gnt;
    last_stall = bus.cpu_stall;
    @(posedge clk);
    exp_rvalid = e_gnt && !dw;
    if (exp_rvalid) exp_rdata = ref_mem[da[7:2]];
    if (e_we) ref_mem[e_addr[7:2]] = e_gnt ? dd : cd;
    if (forced)        denials = 0;
    else if (dr && cr) denials = denials + 1;
    else               denials = 0;
    @(negedge clk);
  endtask

  logic [AW-1:0] p_ca, p_da;
  logic [DW-1:0] p_cd, p_dd, saved;
  logic          p_cr, p_cw, p_dr, p_dw;
  int            bad;

  initial begin
    for (int i = 0; i < 64; i++) begin
      ram[i]     = 32'h0;
      ref_mem[i] = 32'h0;
    end
    model_reset();
    rst = 1'b1;
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 32'h4; bus.cpu_wdata = 32'h1111;
    bus.dma_req = 1'b1; bus.dma_we = 1'b1; bus.dma_addr = 32'h8; bus.dma_wdata = 32'h2222;
    repeat (3) @(negedge clk);
    #1;
    check_val("rst mem_we",     bus.mem_we,     1'b0);
    check_val("rst dma_gnt",    bus.dma_gnt,    1'b0);
    check_val("rst cpu_stall",  bus.cpu_stall,  1'b0);
    check_val("rst dma_rvalid", bus.dma_rvalid, 1'b0);
    check_val("rst ram",        ram[1],         32'h0);
    @(negedge clk);
    rst = 1'b0;

    // DMA write then read with CPU idle
    step(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 32'h10, 32'hCAFE);
    check_val("cafe gnt", last_gnt, 1'b1);
    check_val("cafe ram", ram[4], 32'hCAFE);
    step(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h10, 32'h0);
    step(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    check_val("rd rvalid", bus.dma_rvalid, 1'b0);

    // Continuous contention: forced grant every fifth cycle
    for (int i = 0; i < 15; i++) begin
      step(1'b1, 1'b0, 32'h10, 32'h0, 1'b1, 1'b1, 32'h40 + 32'(4 * i), 32'hA000 + 32'(i));
      check_val("starve gnt",   last_gnt,   (i % 5) == 4);
      check_val("starve stall", last_stall, (i % 5) == 4);
    end

    // Drop after two denials: the count restarts
    step(1'b1, 1'b0, 32'h10, 32'h0, 1'b1, 1'b1, 32'h80, 32'hB0);
    step(1'b1, 1'b0, 32'h10, 32'h0, 1'b1, 1'b1, 32'h80, 32'hB0);
    step(1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 1'b0, 32'h0,  32'h0);
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'b1, 32'h84, 32'hC0 + 32'(i), 1'b1, 1'b1, 32'h88, 32'hB1);
      check_val("restart gnt", last_gnt, i == 4);
    end

    // Reset asserted during a forced DMA write
    for (int i = 0; i < LIMIT; i++) begin
      step(1'b1, 1'b0, 32'h10, 32'h0, 1'b1, 1'b1, 32'h20, 32'hDEADBEEF);
    end
    saved = ram[8];
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 32'h10;
    bus.dma_req = 1'b1; bus.dma_we = 1'b1; bus.dma_addr = 32'h20; bus.dma_wdata = 32'hDEADBEEF;
    #1;
    check_val("force gnt", bus.dma_gnt, 1'b1);
    #1;
    rst = 1'b1;
    #1;
    check_val("arst mem_we",    bus.mem_we,    1'b0);
    check_val("arst dma_gnt",   bus.dma_gnt,   1'b0);
    check_val("arst cpu_stall", bus.cpu_stall, 1'b0);
    @(posedge clk);
    #1;
    check_val("arst ram", ram[8], saved);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    for (int i = 0; i < LIMIT + 1; i++) begin
      step(1'b1, 1'b0, 32'h10, 32'h0, 1'b1, 1'b1, 32'h24, 32'h5A5A);
      check_val("post-rst gnt", last_gnt, i == LIMIT);
    end

    // Randomized traffic respecting the hold-until-granted and stall-replay rules
    p_dr = 1'b0; p_cr = 1'b0; p_cw = 1'b0; p_dw = 1'b0;
    p_ca = '0; p_cd = '0; p_da = '0; p_dd = '0;
    last_stall = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      if (!last_stall) begin
        p_cr = ($urandom_range(0, 9) < 8);
        p_cw = $urandom_range(0, 1) == 1;
        p_ca = 32'($urandom_range(0, 63)) << 2;
        p_cd = $urandom;
      end
      if (!p_dr && ($urandom_range(0, 2) == 0)) begin
        p_dr = 1'b1;
        p_dw = $urandom_range(0, 1) == 1;
        p_da = 32'($urandom_range(0, 63)) << 2;
        p_dd = $urandom;
      end
      step(p_cr, p_cw, p_ca, p_cd, p_dr, p_dw, p_da, p_dd);
      if (last_gnt) p_dr = 1'b0;
    end

    bad = 0;
    for (int i = 0; i < 64; i++) begin
      if (ram[i] !== ref_mem[i]) bad++;
    end
    check_val("ram contents", 64'(bad), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
